// File: rtl/cpu7_imem_responder.sv
// ============================================================================
// cpu7_imem_responder
// ----------------------------------------------------------------------------
// Responder end of the IFU instruction-fetch interface. A fetch request is
// accepted with inst_req/inst_addr, one 32-bit word is read from a
// synchronous-read instruction RAM, and the word is returned on
// inst_valid_f/inst_rdata_f after a configurable number of wait states.
// inst_cancel drops an accepted request whose response has not yet been
// presented. Misaligned fetches can optionally be reported as an address
// exception (ADEF).
//
// Optional feature macro:
//   CPU7_IMEM_ALIGN_CHK_EN  when defined, inst_addr[1:0] != 0 is a fetch
//                           fault: no RAM read, inst_ex = 1,
//                           inst_exccode = ADEF, inst_rdata_f = 0.
//                           When undefined, the low address bits are
//                           ignored and every accept issues a RAM read.
//
// Parameters:
//   ADDR_W       RAM word-address width; ram_addr = inst_addr[ADDR_W+1:2].
//                Upper address bits are ignored (the RAM aliases).
//   WAIT_CYCLES  extra cycles between accept and response, legal 0..7.
//   UC_SEG       inst_addr[31:29] value that marks an uncached fetch.
//
// Ports:
//   clk           clock, single domain
//   reset         synchronous, active-high
//   inst_req      fetch request
//   inst_addr     fetch byte address, sampled only in the accept cycle
//   inst_cancel   drop any accepted-but-unreturned request
//   inst_addr_ok  request accepted this cycle if inst_req is high
//   inst_valid_f  response valid
//   inst_rdata_f  instruction word, 0 when not valid or on a fault
//   inst_count    number of words returned (1 when valid, else 0)
//   inst_ex       fetch exception travels with the response
//   inst_exccode  6'h08 (ADEF) when inst_ex, else 0
//   inst_uncache  response came from the UC_SEG segment
//   ram_en        RAM read strobe
//   ram_addr      RAM word address
//   ram_rdata     RAM data, valid the cycle after ram_en
//
// Handshake: a request transfers in every cycle where inst_req and
// inst_addr_ok are both high. The response is a one-cycle pulse on
// inst_valid_f exactly 1+WAIT_CYCLES cycles after the transfer; there is
// no back-pressure on the response side.
// ============================================================================
module cpu7_imem_responder #(
    parameter int         ADDR_W      = 14,
    parameter int         WAIT_CYCLES = 0,
    parameter logic [2:0] UC_SEG      = 3'b101
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic [31:0]       inst_addr,
    input  logic              inst_cancel,
    output logic              inst_addr_ok,
    output logic              inst_valid_f,
    output logic [31:0]       inst_rdata_f,
    output logic [1:0]        inst_count,
    output logic              inst_ex,
    output logic [5:0]        inst_exccode,
    output logic              inst_uncache,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [31:0]       ram_rdata
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Wait-state count loaded into cnt on accept. The legal range 0..7 fits
    // the 3-bit counter exactly.
    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
    localparam logic [5:0] EXC_ADEF  = 6'h08;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state;
    logic [2:0]        cnt;
    logic [ADDR_W-1:0] addr_q;   // word address of the accepted fetch
    logic              fault_q;  // accepted fetch was misaligned
    logic              uc_q;     // accepted fetch was in the uncached segment

    // ------------------------------------------------------------------------
    // Request-side decode
    // ------------------------------------------------------------------------
    logic              accept;
    logic              fault;
    logic              uc;
    logic              last_wait;
    logic              resp_on;
    logic [ADDR_W-1:0] req_word;

    // Every inst_addr bit is either decoded or deliberately ignored; this
    // fold keeps the ignored bits (aliasing region, low bits when alignment
    // checking is off) from looking like an oversight.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^inst_addr;

    assign req_word = inst_addr[ADDR_W+1:2];
    assign uc       = (inst_addr[31:29] == UC_SEG);

`ifdef CPU7_IMEM_ALIGN_CHK_EN
    assign fault = (inst_addr[1:0] != 2'b00);
`else
    assign fault = 1'b0;
`endif

    // A request is refused only while a response is still in its wait
    // states; a cancel frees the slot in the same cycle so the IFU can
    // redirect without a bubble. Nothing is accepted during reset.
    always_comb begin
        inst_addr_ok = 1'b0;
        if (!reset) begin
            inst_addr_ok = (state != S_WAIT) || inst_cancel;
        end
    end

    assign accept    = inst_req && inst_addr_ok;
    assign last_wait = (state == S_WAIT) && (cnt == 3'd1);

    // ------------------------------------------------------------------------
    // RAM read port
    // ------------------------------------------------------------------------
    // Zero wait states: the read is launched straight from the request so
    // the data lands in the following (RESP) cycle. With wait states the
    // read is launched from the latched address in the final WAIT cycle, so
    // the RAM is idle for the rest of the wait period. A read launched in a
    // cycle that also sees inst_cancel is simply ignored: the FSM leaves
    // WAIT and never reaches RESP for it.
    always_comb begin
        ram_en   = 1'b0;
        ram_addr = '0;
        if (NO_WAIT) begin
            ram_en   = accept && !fault;
            ram_addr = req_word;
        end else begin
            ram_en   = !reset && last_wait && !fault_q;
            ram_addr = addr_q;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    // An accept always wins, whatever the current state: from IDLE and RESP
    // this gives back-to-back fetches, and from WAIT it can only happen with
    // inst_cancel, in which case the pending fetch is overwritten by the new
    // one and its response is never presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= 3'd0;
            addr_q  <= '0;
            fault_q <= 1'b0;
            uc_q    <= 1'b0;
        end else if (accept) begin
            addr_q  <= req_word;
            fault_q <= fault;
            uc_q    <= uc;
            if (NO_WAIT) begin
                state <= S_RESP;
                cnt   <= 3'd0;
            end else begin
                state <= S_WAIT;
                cnt   <= WAIT_LOAD;
            end
        end else begin
            case (state)
                S_WAIT: begin
                    if (inst_cancel) begin
                        // Pending response discarded, no replacement fetch.
                        state <= S_IDLE;
                        cnt   <= 3'd0;
                    end else if (cnt == 3'd1) begin
                        state <= S_RESP;
                        cnt   <= 3'd0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Response outputs
    // ------------------------------------------------------------------------
    // The response fields come straight from registered state; only the
    // data word is taken from the RAM output, which is valid in exactly
    // this cycle. A cancel in RESP does not suppress the response: the IFU
    // is expected to kill it on its side. Reset forces every output low even
    // if the FSM was in RESP when reset was raised.
    assign resp_on = !reset && (state == S_RESP);

    always_comb begin
        inst_valid_f = resp_on;
        inst_count   = {1'b0, resp_on};
        inst_ex      = resp_on && fault_q;
        inst_exccode = (resp_on && fault_q) ? EXC_ADEF : 6'h00;
        inst_uncache = resp_on && uc_q;
        inst_rdata_f = (resp_on && !fault_q) ? ram_rdata : 32'h0;
    end

endmodule

// File: doc/cpu7_imem_responder.md
# cpu7_imem_responder

Responder end of the IFU instruction-fetch interface: accepts `inst_req`/`inst_addr`, reads one 32-bit word from a synchronous-read instruction RAM and returns it on `inst_valid_f`/`inst_rdata_f` with configurable wait states. It honours `inst_cancel` and flags misaligned fetches as exceptions. It sits between the IFU fetch datapath and the instruction SRAM, or a behavioural RAM in simulation.

## Interface
- `ADDR_W`, 14: RAM word-address width; `ram_addr = inst_addr[ADDR_W+1:2]`, upper address bits ignored (aliasing).
- `WAIT_CYCLES`, 0: extra cycles between accept and response, legal range 0..7.
- `UC_SEG`, 3'b101: `inst_addr[31:29]` value marking an uncached fetch.

- `clk` in 1: clock. Single clock domain.
- `reset` in 1: synchronous, active-high.
- `inst_req` in 1: fetch request.
- `inst_addr` in 32: fetch byte address.
- `inst_cancel` in 1: drop any accepted-but-unreturned request.
- `inst_addr_ok` out 1: request accepted this cycle if `inst_req` is high.
- `inst_valid_f` out 1: response valid.
- `inst_rdata_f` out 32: instruction word; 0 when not valid.
- `inst_count` out 2: number of words returned; 2'd1 when valid, else 0.
- `inst_ex` out 1: fetch exception with the response.
- `inst_exccode` out 6: 6'h08 (ADEF) when `inst_ex`, else 0.
- `inst_uncache` out 1: response came from the `UC_SEG` segment.
- `ram_en` out 1: RAM read strobe.
- `ram_addr` out ADDR_W: RAM word address.
- `ram_rdata` in 32: RAM data, valid the cycle after `ram_en`.

## Operation
- FSM states: IDLE, WAIT, RESP.
- `accept = inst_req & inst_addr_ok`.
- `inst_addr_ok = (state != WAIT) | inst_cancel`. The signal is 0 while `reset` is high.
- On accept, the block latches `addr_q`, `fault_q` (misaligned, see Configuration) and `uc_q`.
- With `WAIT_CYCLES == 0`:
  - On accept, next state is RESP.
  - RAM is read in the accept cycle: `ram_en = ~fault`, address taken from `inst_addr`.
- With `WAIT_CYCLES = k > 0`:
  - On accept, next state is WAIT and `cnt` is loaded with k.
  - `cnt` decrements in WAIT; when `cnt == 1`, next state is RESP.
  - RAM is read in the last WAIT cycle (`cnt == 1`), using `addr_q`, with `ram_en = ~fault_q`.
- In RESP:
  - Outputs: `inst_valid_f = 1`, `inst_rdata_f = fault_q ? 0 : ram_rdata`, `inst_ex = fault_q`, `inst_uncache = uc_q`.
  - A same-cycle accept follows the IDLE accept rules (back-to-back fetches are allowed).
  - Without an accept, next state is IDLE.
- Cancel:
  - In WAIT: the pending response is discarded and never presented. Any RAM read already issued for it is ignored. A same-cycle `inst_req` is accepted as a fresh request.
  - In RESP: the current response is still presented; the IFU kills it. A same-cycle request is accepted normally.
  - In IDLE: no effect beyond normal acceptance.
- Fault: no RAM read is issued, but the response keeps the normal latency.

## Timing
- Reset values: state IDLE, `cnt` 0, `inst_valid_f` 0, `inst_rdata_f` 0, `inst_count` 0, `inst_ex` 0, `inst_exccode` 0, `inst_uncache` 0, `ram_en` 0, `inst_addr_ok` 0 during reset.
- Latency is accept cycle N → `inst_valid_f` at N+1+`WAIT_CYCLES`.
- Throughput: 1 fetch/cycle when `WAIT_CYCLES == 0`, else 1 per `WAIT_CYCLES+1` cycles.
- Reset mid-operation: the pending request is dropped and no response is presented after reset deasserts.
- `inst_addr` is sampled only in the accept cycle; later changes have no effect.
- Simultaneous cancel and accept in WAIT: the new request's response arrives at N+1+`WAIT_CYCLES` counted from the cancel cycle.

## Configuration
- `CPU7_IMEM_ALIGN_CHK_EN` defined:
  - `fault = inst_addr[1:0] != 0`.
  - A faulting fetch returns `inst_ex = 1`, `inst_exccode = 6'h08`, `inst_rdata_f = 0`, and issues no `ram_en`.
- Not defined:
  - `inst_addr[1:0]` is ignored.
  - `inst_ex` and `inst_exccode` are tied to 0, and every accept issues a RAM read.

## Test plan
- `WAIT_CYCLES=0`, RAM[0x10]=32'h02800C21; `inst_req` held high with addresses 0x40, 0x44, 0x48 on consecutive cycles → `inst_valid_f` high on 3 consecutive cycles starting N+1, data RAM[0x10], [0x11], [0x12], `inst_count=1`.
- `WAIT_CYCLES=2`, fetch 0x1C00_0000 at cycle N → `inst_addr_ok` low at N+1 and N+2, `ram_en` at N+2, `inst_valid_f` at N+3, `inst_uncache=0`; a fetch of 0xA000_0000 → `inst_uncache=1`.
- `WAIT_CYCLES=2`, fetch 0x100 at N, then `inst_cancel` with new addr 0x200 at N+1 → no response for 0x100; `inst_valid_f` at N+4 carrying RAM[0x80].
- `CPU7_IMEM_ALIGN_CHK_EN` defined, fetch 0x102 → no `ram_en`; response `inst_ex=1`, `inst_exccode=6'h08`, `inst_rdata_f=0`. Without the macro → normal data from word 0x40 and `inst_ex=0`.
- `reset` asserted for 1 cycle at N+1 while `WAIT_CYCLES=2` fetch pending → all outputs 0, `inst_valid_f` never asserts for that fetch, and the next accept works normally.
